// File: rtl/uart_tx_frame_scheduler_if.sv
// Handshake between the frame scheduler and the shared UART transmitter.
// The scheduler offers one byte at a time; the transmitter reports when it
// has taken the byte and when the byte has left the serial line.
interface uart_tx_frame_scheduler_if;
  logic       tx_has_data;
  logic [7:0] tx_data;
  logic       tx_is_transmitting;
  logic       tx_transmission_done;

  modport master (
    output tx_has_data,
    output tx_data,
    input  tx_is_transmitting,
    input  tx_transmission_done
  );

  modport slave (
    input  tx_has_data,
    input  tx_data,
    output tx_is_transmitting,
    output tx_transmission_done
  );
endinterface

// File: rtl/uart_tx_frame_scheduler.sv
// Shares one UART transmitter between requester A (measurement responses)
// and requester B (status/error reports). Frames are granted round-robin,
// latched, and fed to the transmitter byte by byte (most-significant byte
// first) with an idle gap between bytes. The granted requester receives a
// one-cycle ack when its frame is done, or when the transmitter refuses a
// byte for too long (frame abandoned, timeout_err pulsed together with ack).
module uart_tx_frame_scheduler #(
  parameter int BYTES_PER_FRAME = 2,
  parameter int GAP_CYCLES      = 4,
  parameter int ACCEPT_TIMEOUT  = 255
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         req_a,
  input  logic [8*BYTES_PER_FRAME-1:0] frame_a,
  output logic                         ack_a,
  input  logic                         req_b,
  input  logic [8*BYTES_PER_FRAME-1:0] frame_b,
  output logic                         ack_b,
  output logic                         busy,
  output logic                         grant_id,
  output logic                         timeout_err,
  uart_tx_frame_scheduler_if.master    tx
);

  localparam int FW = 8 * BYTES_PER_FRAME;
  localparam int TW = $clog2(ACCEPT_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [TW-1:0] TMO_LAST = TW'(ACCEPT_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  localparam logic [2:0]    IDX_LAST = 3'(BYTES_PER_FRAME - 1);
  localparam logic          ID_A     = 1'b0;
  localparam logic          ID_B     = 1'b1;

  typedef enum logic [2:0] {
    S_SYNC      = 3'd0,
    S_IDLE      = 3'd1,
    S_LAUNCH    = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4,
    S_FINISH    = 3'd5
  } state_t;

  // The byte currently at the head of the frame shift register.
  function automatic logic [7:0] lead_byte(input logic [FW-1:0] frame);
    return frame[FW-1 -: 8];
  endfunction

  state_t        state_q, state_d;
  logic [FW-1:0] shift_q, shift_d;
  logic [2:0]    idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          last_q, last_d;
  logic          grant_q, grant_d;
  logic          busy_q, busy_d;
  logic          ack_a_q, ack_a_d;
  logic          ack_b_q, ack_b_d;
  logic          tmo_err_q, tmo_err_d;
  logic          has_data_q, has_data_d;
  logic [7:0]    data_q, data_d;
  logic          done_prev_q;
  logic          done_rise_s;

  // Each completion is counted once per rising edge of done, however long it stays high.
  assign done_rise_s = tx.tx_transmission_done & ~done_prev_q;

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_SYNC;
      shift_q     <= '0;
      idx_q       <= 3'd0;
      gap_q       <= '0;
      tmo_q       <= '0;
      last_q      <= ID_B;
      grant_q     <= 1'b0;
      busy_q      <= 1'b0;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      tmo_err_q   <= 1'b0;
      has_data_q  <= 1'b0;
      data_q      <= 8'h00;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      tmo_q       <= tmo_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      ack_a_q     <= ack_a_d;
      ack_b_q     <= ack_b_d;
      tmo_err_q   <= tmo_err_d;
      has_data_q  <= has_data_d;
      data_q      <= data_d;
      done_prev_q <= tx.tx_transmission_done;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead so they leave registered.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    tmo_d      = tmo_q;
    last_d     = last_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;
    tmo_err_d  = 1'b0;
    has_data_d = has_data_q;
    data_d     = data_q;

    case (state_q)
      // Do not start while the transmitter is still busy with a byte from before reset.
      S_SYNC: begin
        has_data_d = 1'b0;
        busy_d     = 1'b0;
        if (!tx.tx_is_transmitting) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SYNC;
        end
      end

      S_IDLE: begin
        if (req_a || req_b) begin
          // A wins when alone or when B was served last; otherwise B.
          if (req_a && (!req_b || (last_q == ID_B))) begin
            grant_d = ID_A;
            shift_d = frame_a;
          end else begin
            grant_d = ID_B;
            shift_d = frame_b;
          end
          last_d     = grant_d;
          busy_d     = 1'b1;
          idx_d      = 3'd0;
          tmo_d      = '0;
          has_data_d = 1'b1;
          data_d     = lead_byte(shift_d);
          state_d    = S_LAUNCH;
        end else begin
          busy_d = 1'b0;
        end
      end

      S_LAUNCH: begin
        if (tx.tx_is_transmitting) begin
          has_data_d = 1'b0;
          state_d    = S_WAIT_DONE;
        end else if (tmo_q == TMO_LAST) begin
          // Transmitter never took the byte: abandon the frame and release the requester.
          has_data_d = 1'b0;
          tmo_err_d  = 1'b1;
          ack_a_d    = (grant_q == ID_A);
          ack_b_d    = (grant_q == ID_B);
          state_d    = S_SYNC;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end

      // tx_data is held untouched here: the transmitter samples it live.
      S_WAIT_DONE: begin
        if (done_rise_s) begin
          if (idx_q == IDX_LAST) begin
            ack_a_d = (grant_q == ID_A);
            ack_b_d = (grant_q == ID_B);
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = shift_q << 8;
            gap_d   = '0;
            state_d = S_GAP;
          end
        end else begin
          state_d = S_WAIT_DONE;
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          has_data_d = 1'b1;
          data_d     = lead_byte(shift_q);
          tmo_d      = '0;
          state_d    = S_LAUNCH;
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end

      // Ack is visible this cycle with busy still high; busy drops on the next.
      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        has_data_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = S_SYNC;
      end
    endcase
  end

  assign ack_a          = ack_a_q;
  assign ack_b          = ack_b_q;
  assign busy           = busy_q;
  assign grant_id       = grant_q;
  assign timeout_err    = tmo_err_q;
  assign tx.tx_has_data = has_data_q;
  assign tx.tx_data     = data_q;

endmodule

// File: tb/tb_uart_tx_frame_scheduler.sv
// Bench for uart_tx_frame_scheduler: a UART transmitter model that rebuilds
// each byte from tx_data sampled mid-bit, a negedge monitor, a vector table,
// hand-written corner sequences and randomized frames against a round-robin
// reference model.
module tb_uart_tx_frame_scheduler;
  localparam int BPF = 2;
  localparam int GAP = 4;
  localparam int TMO = 10;
  localparam int CPB = 4;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           req_a, req_b;
  logic [8*BPF-1:0] frame_a, frame_b;
  logic           ack_a, ack_b, busy, grant_id, timeout_err;

  uart_tx_frame_scheduler_if txif();

  uart_tx_frame_scheduler #(
    .BYTES_PER_FRAME(BPF), .GAP_CYCLES(GAP), .ACCEPT_TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_a(req_a), .frame_a(frame_a), .ack_a(ack_a),
    .req_b(req_b), .frame_b(frame_b), .ack_b(ack_b),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err),
    .tx(txif)
  );

  always #5 clock = ~clock;

  // ---------------- transmitter model ----------------
  bit         model_en = 1'b0;
  int         done_len = 1;
  int         m_cnt, done_left;
  bit         m_active;
  logic [7:0] m_byte;
  logic [7:0] rxq[$];

  // Start bit, 8 data bits LSB first, stop bit; done pulses for done_len cycles.
  always @(posedge clock) begin
    if (!model_en) begin
      m_active <= 1'b0;
      m_cnt <= 0;
      done_left <= 0;
      txif.tx_is_transmitting <= 1'b0;
      txif.tx_transmission_done <= 1'b0;
    end else if (m_active) begin
      if (m_cnt == 10*CPB-1) begin
        m_active <= 1'b0;
        txif.tx_is_transmitting <= 1'b0;
        txif.tx_transmission_done <= 1'b1;
        done_left <= done_len - 1;
        rxq.push_back(m_byte);
      end else begin
        m_cnt <= m_cnt + 1;
        for (int b = 0; b < 8; b++)
          if (m_cnt == CPB*(b+1) + CPB/2) m_byte[b] <= txif.tx_data[b];
      end
    end else begin
      txif.tx_transmission_done <= (done_left > 0);
      if (done_left > 0) done_left <= done_left - 1;
      if (txif.tx_has_data) begin
        m_active <= 1'b1;
        m_cnt <= 0;
        txif.tx_is_transmitting <= 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  int cyc = 0, n_ack_a, n_ack_b, n_tmo, n_tmo_with_ack, hd_cycles, hd_rise_tx;
  int min_gap, last_done_cyc;
  bit done_pend, busy_prev, done_prev_m, hd_prev;
  bit grants[$];

  // Records acks, grants, timeouts and the done-to-next-byte gap within a frame.
  always @(negedge clock) begin
    cyc++;
    if (ack_a === 1'b1) n_ack_a++;
    if (ack_b === 1'b1) n_ack_b++;
    if (timeout_err === 1'b1) begin
      n_tmo++;
      if (ack_a === 1'b1 || ack_b === 1'b1) n_tmo_with_ack++;
    end
    if (busy === 1'b1 && !busy_prev) grants.push_back(grant_id);
    if (txif.tx_has_data === 1'b1) hd_cycles++;
    if (txif.tx_has_data === 1'b1 && !hd_prev) begin
      if (txif.tx_is_transmitting === 1'b1) hd_rise_tx++;
      if (done_pend) begin
        if (cyc - last_done_cyc < min_gap) min_gap = cyc - last_done_cyc;
        done_pend = 1'b0;
      end
    end
    if (txif.tx_transmission_done === 1'b1 && !done_prev_m) begin
      done_pend = 1'b1;
      last_done_cyc = cyc;
    end
    if (ack_a === 1'b1 || ack_b === 1'b1) done_pend = 1'b0;
    busy_prev   = (busy === 1'b1);
    hd_prev     = (txif.tx_has_data === 1'b1);
    done_prev_m = (txif.tx_transmission_done === 1'b1);
  end

  // ---------------- checking helpers ----------------
  int n_pass = 0, n_total = 0;
  bit ref_last = 1'b1;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_logs();
    n_ack_a = 0; n_ack_b = 0; n_tmo = 0; n_tmo_with_ack = 0;
    hd_cycles = 0; hd_rise_tx = 0; min_gap = 9999; done_pend = 1'b0;
    grants.delete(); rxq.delete(); exp_q.delete();
  endtask

  // Round-robin rule: a lone requester wins; on a tie the one not served last wins.
  function automatic bit rr_pick(input bit ra, input bit rb);
    bit id;
    if (ra && rb) id = ~ref_last;
    else          id = rb;
    ref_last = id;
    return id;
  endfunction

  function automatic void push_frame(input logic [8*BPF-1:0] f);
    for (int k = BPF-1; k >= 0; k--) exp_q.push_back(f[8*k +: 8]);
  endfunction

  task automatic check_bytes(input string name);
    int bad = 0;
    check({name, "_count"}, rxq.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      if (k >= rxq.size() || rxq[k] !== exp_q[k]) bad++;
    check({name, "_bytes"}, bad, 0);
  endtask

  // Raise requests, drop each on its ack (unless held), stop after nacks acks.
  task automatic run(input bit ra, input bit rb, input logic [8*BPF-1:0] fa,
                     input logic [8*BPF-1:0] fb, input int nacks, input bit hold,
                     output bit ok);
    int cnt = 0;
    ok = 1'b0;
    frame_a = fa; frame_b = fb; req_a = ra; req_b = rb;
    for (int t = 0; t < 3000; t++) begin
      tick();
      if (ack_a === 1'b1 || ack_b === 1'b1) begin
        cnt++;
        if (ack_a === 1'b1 && !hold) req_a = 1'b0;
        if (ack_b === 1'b1 && !hold) req_b = 1'b0;
        if (cnt >= nacks) begin
          ok = 1'b1;
          break;
        end
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    tick(20);
  endtask

  typedef struct {
    bit ra; bit rb; logic [15:0] fa; logic [15:0] fb; int dl; int nacks;
    logic [31:0] exp_bytes; int exp_nbytes; bit exp_first; int exp_na; int exp_nb;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vt[8];
    bit ok, found;
    logic [31:0] got;
    bit exp_ids[$];
    int sel;
    bit ra, rb, id;
    logic [15:0] fa, fb;

    vt[0] = '{1'b1, 1'b0, 16'hA55A, 16'h0000, 1, 1, 32'h0000A55A, 2, 1'b0, 1, 0};
    vt[1] = '{1'b0, 1'b1, 16'h0000, 16'h1234, 2, 1, 32'h00001234, 2, 1'b1, 0, 1};
    vt[2] = '{1'b1, 1'b1, 16'h0102, 16'h0304, 1, 2, 32'h01020304, 4, 1'b0, 1, 1};
    vt[3] = '{1'b1, 1'b1, 16'hBEEF, 16'hCAFE, 2, 2, 32'hBEEFCAFE, 4, 1'b0, 1, 1};
    vt[4] = '{1'b0, 1'b1, 16'h0000, 16'h00FF, 1, 1, 32'h000000FF, 2, 1'b1, 0, 1};
    vt[5] = '{1'b1, 1'b1, 16'h1111, 16'h2222, 2, 2, 32'h11112222, 4, 1'b0, 1, 1};
    vt[6] = '{1'b1, 1'b0, 16'h5555, 16'h0000, 1, 1, 32'h00005555, 2, 1'b0, 1, 0};
    vt[7] = '{1'b1, 1'b1, 16'h7777, 16'h8888, 2, 2, 32'h88887777, 4, 1'b1, 1, 1};

    reset_n = 1'b0; req_a = 1'b0; req_b = 1'b0; frame_a = '0; frame_b = '0;
    tick(3);
    check("rst_busy", busy, 1'b0);
    check("rst_ack_a", ack_a, 1'b0);
    check("rst_ack_b", ack_b, 1'b0);
    check("rst_grant_id", grant_id, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_has_data", txif.tx_has_data, 1'b0);
    check("rst_tx_data", txif.tx_data, 8'h00);
    model_en = 1'b1;
    tick(1);
    reset_n = 1'b1;
    tick(3);

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      clear_logs();
      done_len = vt[i].dl;
      run(vt[i].ra, vt[i].rb, vt[i].fa, vt[i].fb, vt[i].nacks, 1'b0, ok);
      check($sformatf("v%0d_complete", i), ok, 1'b1);
      check($sformatf("v%0d_nbytes", i), rxq.size(), vt[i].exp_nbytes);
      got = '0;
      foreach (rxq[k]) got = {got[23:0], rxq[k]};
      check($sformatf("v%0d_bytes", i), got, vt[i].exp_bytes);
      check($sformatf("v%0d_first_grant", i), (grants.size() > 0) ? int'(grants[0]) : 2,
            vt[i].exp_first);
      check($sformatf("v%0d_ack_a", i), n_ack_a, vt[i].exp_na);
      check($sformatf("v%0d_ack_b", i), n_ack_b, vt[i].exp_nb);
      check($sformatf("v%0d_gap_ok", i), (min_gap >= GAP), 1'b1);
      check($sformatf("v%0d_no_timeout", i), n_tmo, 0);
      ref_last = (vt[i].ra && vt[i].rb) ? ~vt[i].exp_first : vt[i].exp_first;
    end

    // Transmitter never accepts: timeout, ack to A, then B served normally.
    model_en = 1'b0;
    tick(2);
    clear_logs();
    run(1'b1, 1'b0, 16'hDEAD, 16'h0000, 1, 1'b0, ok);
    id = rr_pick(1'b1, 1'b0);
    check("tmo_complete", ok, 1'b1);
    check("tmo_pulses", n_tmo, 1);
    check("tmo_with_ack", n_tmo_with_ack, 1);
    check("tmo_ack_a", n_ack_a, 1);
    check("tmo_ack_b", n_ack_b, 0);
    check("tmo_has_data_cycles", hd_cycles, TMO);
    check("tmo_busy_released", busy, 1'b0);
    model_en = 1'b1;
    tick(2);
    clear_logs();
    done_len = 1;
    run(1'b0, 1'b1, 16'h0000, 16'h4B1D, 1, 1'b0, ok);
    id = rr_pick(1'b0, 1'b1);
    push_frame(16'h4B1D);
    check("after_tmo_complete", ok, 1'b1);
    check_bytes("after_tmo");
    check("after_tmo_ack_b", n_ack_b, 1);
    check("after_tmo_no_timeout", n_tmo, 0);

    // Reset mid-byte with req_a held: no ack for the lost frame, no launch until tx idle.
    clear_logs();
    frame_a = 16'hC33C; req_a = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      tick();
      if (txif.tx_is_transmitting === 1'b1) found = 1'b1;
    end
    check("rstmid_started", found, 1'b1);
    tick(10);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_ack_a", ack_a, 1'b0);
    check("rstmid_grant_id", grant_id, 1'b0);
    check("rstmid_has_data", txif.tx_has_data, 1'b0);
    check("rstmid_tx_data", txif.tx_data, 8'h00);
    clear_logs();
    ref_last = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 2000 && !found; t++) begin
      tick();
      if (ack_a === 1'b1) begin
        found = 1'b1;
        req_a = 1'b0;
      end
    end
    req_a = 1'b0;
    tick(20);
    id = rr_pick(1'b1, 1'b0);
    check("rstmid_resent", found, 1'b1);
    check("rstmid_no_early_launch", hd_rise_tx, 0);
    check("rstmid_ack_count", n_ack_a, 1);
    check("rstmid_nbytes", rxq.size(), 3);
    got = (rxq.size() >= 2) ? {16'h0000, rxq[rxq.size()-2], rxq[rxq.size()-1]} : 32'hFFFFFFFF;
    check("rstmid_bytes", got, 32'h0000C33C);

    // req_b pulsed and withdrawn while A is busy; frame_a changed after grant.
    clear_logs();
    frame_a = 16'h6C93; req_a = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 50 && !found; t++) begin
      tick();
      if (busy === 1'b1) found = 1'b1;
    end
    check("pulse_granted", found, 1'b1);
    tick(3);
    req_b = 1'b1; frame_b = 16'hFFFF; frame_a = 16'h0000;
    tick(1);
    req_b = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 2000 && !found; t++) begin
      tick();
      if (ack_a === 1'b1) begin
        found = 1'b1;
        req_a = 1'b0;
      end
    end
    tick(30);
    id = rr_pick(1'b1, 1'b0);
    push_frame(16'h6C93);
    check("pulse_ack_a", n_ack_a, 1);
    check("pulse_ack_b", n_ack_b, 0);
    check("pulse_grants", grants.size(), 1);
    check_bytes("pulse");

    // Both requests held after a fresh reset: grants alternate A, B, A, B.
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    ref_last = 1'b1;
    clear_logs();
    exp_ids.delete();
    for (int k = 0; k < 4; k++) begin
      exp_ids.push_back(rr_pick(1'b1, 1'b1));
      push_frame(exp_ids[k] ? 16'hF0F0 : 16'h0F0F);
    end
    run(1'b1, 1'b1, 16'h0F0F, 16'hF0F0, 4, 1'b1, ok);
    check("alt_complete", ok, 1'b1);
    check("alt_ngrants", grants.size(), 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("alt_grant%0d", k), (k < grants.size()) ? int'(grants[k]) : 2,
            int'(exp_ids[k]));
    check("alt_ack_a", n_ack_a, 2);
    check("alt_ack_b", n_ack_b, 2);
    check_bytes("alt");

    // Randomized frames, request patterns and done lengths against the reference model.
    for (int i = 0; i < 10; i++) begin
      clear_logs();
      sel = $urandom_range(1, 3);
      ra = sel[0]; rb = sel[1];
      fa = 16'($urandom); fb = 16'($urandom);
      done_len = $urandom_range(1, 3);
      exp_ids.delete();
      if (ra && rb) begin
        exp_ids.push_back(rr_pick(1'b1, 1'b1));
        exp_ids.push_back(~exp_ids[0]);
        ref_last = exp_ids[1];
      end else begin
        exp_ids.push_back(rr_pick(ra, rb));
      end
      foreach (exp_ids[k]) push_frame(exp_ids[k] ? fb : fa);
      run(ra, rb, fa, fb, exp_ids.size(), 1'b0, ok);
      check($sformatf("rnd%0d_complete", i), ok, 1'b1);
      check_bytes($sformatf("rnd%0d", i));
      check($sformatf("rnd%0d_first_grant", i), (grants.size() > 0) ? int'(grants[0]) : 2,
            int'(exp_ids[0]));
      check($sformatf("rnd%0d_ack_a", i), n_ack_a, int'(ra));
      check($sformatf("rnd%0d_ack_b", i), n_ack_b, int'(rb));
      check($sformatf("rnd%0d_gap_ok", i), (min_gap >= GAP), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_tx_frame_scheduler.md
Name: uart_tx_frame_scheduler

Overview:
Shares the single UART transmitter between two requesters (A: sensor measurement response, B: status/error report).
Each requester submits a fixed-length multi-byte frame. The block arbitrates round-robin, latches the winning frame, and sequences it byte by byte into the transmitter using its has_data / is_transmitting / transmission_done handshake. It enforces a minimum idle gap between bytes and acknowledges the requester when the whole frame has been sent.

Parameters:
BYTES_PER_FRAME, 2, number of bytes per frame (1..8)
GAP_CYCLES, 4, idle clocks between end of one byte and launch of the next (min 2)
ACCEPT_TIMEOUT, 255, max clocks to wait for tx_is_transmitting after raising tx_has_data

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous reset, active-low
req_a  in  1  requester A frame pending; hold high until ack_a
frame_a  in  8*BYTES_PER_FRAME  A payload, sampled at grant
ack_a  out  1  one-cycle pulse: A frame fully sent
req_b  in  1  requester B frame pending; hold high until ack_b
frame_b  in  8*BYTES_PER_FRAME  B payload, sampled at grant
ack_b  out  1  one-cycle pulse: B frame fully sent
busy  out  1  high from grant until ack cycle inclusive
grant_id  out  1  0 = A, 1 = B; valid while busy
timeout_err  out  1  one-cycle pulse: transmitter failed to accept a byte
tx_has_data  out  1  to transmitter: byte ready
tx_data  out  8  to transmitter: byte value
tx_is_transmitting  in  1  from transmitter
tx_transmission_done  in  1  from transmitter (may stay high >1 cycle)

Behaviour:
- Interface: one clock, named clock. Reset is synchronous and active-low, named reset_n. All outputs are registered.
- Reset values: ack_a, ack_b, busy, grant_id, timeout_err, tx_has_data are 0; tx_data is 8'h00. last_grant = B, so A wins the first tie. State = SYNC.
- SYNC: wait until tx_is_transmitting = 0 for one cycle (covers reset during an in-flight byte), then go to IDLE.
- IDLE: if any req, arbitrate:
  - Only one requester: grant it.
  - Both: grant the one that is not last_grant.
  - On grant: latch frame into a shift register, set grant_id and busy, clear byte_idx, update last_grant, go to LAUNCH.
  - Grant cycle is the clock after req is first seen.
- LAUNCH: drive tx_data = current byte and tx_has_data = 1.
  - Byte order: most-significant byte first, i.e. frame[8*BYTES_PER_FRAME-1 -: 8] goes first.
  - Hold tx_has_data until tx_is_transmitting = 1, then drop it the next cycle and go to WAIT_DONE.
  - If ACCEPT_TIMEOUT cycles pass without acceptance: drop tx_has_data, pulse timeout_err, pulse the ack of the granted requester (frame abandoned), go to SYNC.
- WAIT_DONE: tx_data must stay stable, because the transmitter reads it live during data bits.
  - Detect a rising edge of tx_transmission_done (registered previous value). Each edge counts as exactly one byte completion, regardless of how long done stays high.
  - On the edge: if byte_idx = BYTES_PER_FRAME-1, go to FINISH; else increment byte_idx, shift in the next byte, go to GAP.
- GAP: count GAP_CYCLES with tx_has_data = 0, then go to LAUNCH.
- FINISH: pulse the ack of the granted requester for 1 cycle; busy stays high this cycle and goes low the next. Go to IDLE.
  - A req still high in the cycle after ack is treated as a new frame.
- Requests:
  - req dropped before grant: request withdrawn, nothing sent.
  - req dropped after grant: ignored; the frame completes and ack is still pulsed.
  - frame_x changes after grant: no effect.
- tx_transmission_done edges seen outside WAIT_DONE are ignored.
- Timeout counter width: ceil(log2(ACCEPT_TIMEOUT+1)). Gap counter width: ceil(log2(GAP_CYCLES+1)). byte_idx width: 3 bits.
- Reset (reset_n = 0) at any time: all state returns to the reset values on the next edge; the pending frame is discarded without ack.

Test Plan:
- Single A frame 16'hA55A with a transmitter model (CLOCKS_PER_BIT = 4) → serial bytes 8'hA5 then 8'h5A. ≥GAP_CYCLES idle clocks between done edge and next tx_has_data. ack_a pulses once. ack_b never pulses.
- req_a and req_b raised in the same cycle, both frames 16'h0102 / 16'h0304 → A is sent first (bytes 01, 02), then B (03, 04). Repeat with both requests held → grants alternate A, B, A, B.
- tx_transmission_done held high 2 cycles per byte → exactly BYTES_PER_FRAME completions counted, no skipped bytes.
- tx_is_transmitting tied 0 with ACCEPT_TIMEOUT = 10 → timeout_err pulses after 10 cycles, ack_a pulses, state returns to SYNC/IDLE, and a later req_b is served normally.
- reset_n asserted for 1 cycle while tx_is_transmitting = 1 mid-byte → all outputs 0 next cycle, no ack. No new tx_has_data until tx_is_transmitting falls.
- req_b pulsed for 1 cycle while A is busy and dropped before grant → B never granted, ack_b stays 0.
